// File: rtl/elastic_buffer_skp_ctrl_if.sv
// Read-side signal bundle between the RX elastic buffer and its SKP scheduler.
// The buffer side (master) supplies fill level and head symbols; the scheduler (slave) steers the pointer.
interface elastic_buffer_skp_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned CNT_WIDTH  = 8
);
  logic                  enable;
  logic [ADDR_WIDTH:0]   fill_level;
  logic [9:0]            rd_sym;
  logic [9:0]            rd_sym_nxt;
  logic [1:0]            rd_inc;
  logic                  out_vld;
  logic                  skp_added;
  logic                  skp_deleted;
  logic                  underflow;
  logic                  overflow;
  logic [CNT_WIDTH-1:0]  add_cnt;
  logic [CNT_WIDTH-1:0]  del_cnt;

  modport master (
    output enable, fill_level, rd_sym, rd_sym_nxt,
    input  rd_inc, out_vld, skp_added, skp_deleted, underflow, overflow, add_cnt, del_cnt
  );

  modport slave (
    input  enable, fill_level, rd_sym, rd_sym_nxt,
    output rd_inc, out_vld, skp_added, skp_deleted, underflow, overflow, add_cnt, del_cnt
  );
endinterface

// File: rtl/elastic_buffer_skp_ctrl.sv
// Elastic-buffer read scheduler: primes the buffer, then holds/advances/skips the read pointer
// inside COM+SKP ordered sets to keep occupancy centred, with under/overflow and adjust statistics.
module elastic_buffer_skp_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned HALF_FULL      = 8,
  parameter int unsigned ADD_THRESHOLD  = 5,
  parameter int unsigned DEL_THRESHOLD  = 11,
  parameter logic [9:0]  COM_SYM        = 10'h1BC,
  parameter logic [9:0]  SKP_SYM        = 10'h1A1,
  parameter int unsigned STARTUP_CYCLES = 9,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input logic                    lclk,
  input logic                    lrst_n,
  elastic_buffer_skp_ctrl_if.slave bus
);

  localparam int unsigned FW = ADDR_WIDTH + 1;
  localparam int unsigned SW = $clog2(STARTUP_CYCLES + 1);

  localparam logic [FW-1:0] LvlHalf  = FW'(HALF_FULL);
  localparam logic [FW-1:0] LvlAdd   = FW'(ADD_THRESHOLD);
  localparam logic [FW-1:0] LvlDel   = FW'(DEL_THRESHOLD);
  localparam logic [FW-1:0] LvlFull  = FW'(FIFO_DEPTH);
  localparam logic [SW-1:0] StartEnd = SW'(STARTUP_CYCLES);

  typedef enum logic [1:0] {StFill, StRun, StOs} state_e;

  state_e               state_q, state_d;
  logic [SW-1:0]        start_cnt_q, start_cnt_d;
  logic                 adj_done_q, adj_done_d;
  logic [CNT_WIDTH-1:0] add_cnt_q, add_cnt_d;
  logic [CNT_WIDTH-1:0] del_cnt_q, del_cnt_d;

  logic head_com, head_skp, nxt_skp, fill_empty, fill_full;

  assign head_com   = (bus.rd_sym == COM_SYM);
  assign head_skp   = (bus.rd_sym == SKP_SYM);
  assign nxt_skp    = (bus.rd_sym_nxt == SKP_SYM);
  assign fill_empty = (bus.fill_level == '0);
  assign fill_full  = (bus.fill_level == LvlFull);

  always_comb begin
    state_d         = state_q;
    start_cnt_d     = start_cnt_q;
    adj_done_d      = adj_done_q;
    bus.rd_inc      = 2'd0;
    bus.out_vld     = 1'b0;
    bus.skp_added   = 1'b0;
    bus.skp_deleted = 1'b0;
    bus.underflow   = 1'b0;
    bus.overflow    = 1'b0;

    if (!bus.enable) begin
      // Disable suppresses delivery and re-primes from scratch.
      state_d     = StFill;
      start_cnt_d = '0;
      adj_done_d  = 1'b0;
    end else begin
      unique case (state_q)
        StFill: begin
          if (start_cnt_q < StartEnd) start_cnt_d = start_cnt_q + 1'b1;
          if (start_cnt_d == StartEnd && bus.fill_level >= LvlHalf) state_d = StRun;
        end
        StRun, StOs: begin
          if (fill_empty) begin
            bus.underflow = 1'b1;
            state_d       = StFill;
            start_cnt_d   = '0;
          end else begin
            bus.out_vld  = 1'b1;
            bus.rd_inc   = 2'd1;
            bus.overflow = fill_full;
            if (state_q == StOs && head_skp && !adj_done_q) begin
              if (bus.fill_level < LvlAdd) begin
                bus.rd_inc    = 2'd0;
                bus.skp_added = 1'b1;
                adj_done_d    = 1'b1;
              end else if (nxt_skp && bus.fill_level > LvlDel) begin
                // Needs a second SKP behind the head so the set keeps at least one.
                bus.rd_inc      = 2'd2;
                bus.skp_deleted = 1'b1;
                adj_done_d      = 1'b1;
              end
            end
            if (head_com) begin
              state_d    = StOs;
              adj_done_d = 1'b0;
            end else if (!(state_q == StOs && head_skp)) begin
              state_d = StRun;
            end
          end
        end
        default: state_d = StFill;
      endcase
    end
  end

  always_comb begin
    add_cnt_d = add_cnt_q;
    del_cnt_d = del_cnt_q;
    if (bus.skp_added && add_cnt_q != '1) add_cnt_d = add_cnt_q + 1'b1;
    if (bus.skp_deleted && del_cnt_q != '1) del_cnt_d = del_cnt_q + 1'b1;
  end

  assign bus.add_cnt = add_cnt_q;
  assign bus.del_cnt = del_cnt_q;

  always_ff @(posedge lclk or negedge lrst_n) begin
    if (!lrst_n) begin
      state_q     <= StFill;
      start_cnt_q <= '0;
      adj_done_q  <= 1'b0;
      add_cnt_q   <= '0;
      del_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      start_cnt_q <= start_cnt_d;
      adj_done_q  <= adj_done_d;
      add_cnt_q   <= add_cnt_d;
      del_cnt_q   <= del_cnt_d;
    end
  end

endmodule

// File: tb/tb_elastic_buffer_skp_ctrl.sv
// Self-checking bench for elastic_buffer_skp_ctrl: hand-derived vector table, corner sequences,
// and randomized traffic against a rule-level reference model.
module tb_elastic_buffer_skp_ctrl;

  localparam logic [9:0] COM = 10'h1BC;
  localparam logic [9:0] SKP = 10'h1A1;
  localparam logic [9:0] DAT = 10'h055;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  elastic_buffer_skp_ctrl_if #(.ADDR_WIDTH(4), .CNT_WIDTH(8)) bus ();

  elastic_buffer_skp_ctrl dut (
    .lclk   (clk),
    .lrst_n (rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: "priming" vs "delivering", whether the head sits inside an ordered set,
  // and whether that set has already been adjusted.
  bit m_delivering, m_in_set, m_adjusted;
  int m_prime_cycles, m_add, m_del;
  bit n_delivering, n_in_set, n_adjusted;
  int n_prime_cycles, n_add, n_del;
  int e_inc;
  bit e_vld, e_add, e_del, e_unf, e_ovf;

  function automatic void model_reset();
    m_delivering = 0; m_in_set = 0; m_adjusted = 0;
    m_prime_cycles = 0; m_add = 0; m_del = 0;
  endfunction

  function automatic void model_eval(bit en, int fill, logic [9:0] s, logic [9:0] nx);
    e_inc = 0; e_vld = 0; e_add = 0; e_del = 0; e_unf = 0; e_ovf = 0;
    n_delivering = m_delivering; n_in_set = m_in_set; n_adjusted = m_adjusted;
    n_prime_cycles = m_prime_cycles;
    if (!en) begin
      n_delivering = 0; n_in_set = 0; n_prime_cycles = 0;
    end else if (!m_delivering) begin
      n_prime_cycles = (m_prime_cycles + 1 > 9) ? 9 : m_prime_cycles + 1;
      if (n_prime_cycles == 9 && fill >= 8) n_delivering = 1;
    end else if (fill == 0) begin
      e_unf = 1; n_delivering = 0; n_in_set = 0; n_prime_cycles = 0;
    end else begin
      e_vld = 1; e_inc = 1; e_ovf = (fill == 16);
      if (m_in_set && s == SKP && !m_adjusted) begin
        if (fill < 5) begin
          e_inc = 0; e_add = 1; n_adjusted = 1;
        end else if (nx == SKP && fill > 11) begin
          e_inc = 2; e_del = 1; n_adjusted = 1;
        end
      end
      n_in_set = (s == COM) || (m_in_set && s == SKP);
      if (s == COM) n_adjusted = 0;
    end
    n_add = e_add ? ((m_add + 1 > 255) ? 255 : m_add + 1) : m_add;
    n_del = e_del ? ((m_del + 1 > 255) ? 255 : m_del + 1) : m_del;
  endfunction

  function automatic void model_commit();
    m_delivering = n_delivering; m_in_set = n_in_set; m_adjusted = n_adjusted;
    m_prime_cycles = n_prime_cycles; m_add = n_add; m_del = n_del;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Called just after a rising edge; leaves outputs settled mid-cycle.
  task automatic drive(input bit en, input int fill, input logic [9:0] s, input logic [9:0] nx);
    bus.enable     = en;
    bus.fill_level = 5'(fill);
    bus.rd_sym     = s;
    bus.rd_sym_nxt = nx;
    model_eval(en, fill, s, nx);
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_commit();
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " rd_inc"}, int'(bus.rd_inc), e_inc);
    chk({tag, " out_vld"}, int'(bus.out_vld), int'(e_vld));
    chk({tag, " skp_added"}, int'(bus.skp_added), int'(e_add));
    chk({tag, " skp_deleted"}, int'(bus.skp_deleted), int'(e_del));
    chk({tag, " underflow"}, int'(bus.underflow), int'(e_unf));
    chk({tag, " overflow"}, int'(bus.overflow), int'(e_ovf));
    chk({tag, " add_cnt"}, int'(bus.add_cnt), m_add);
    chk({tag, " del_cnt"}, int'(bus.del_cnt), m_del);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit         en;
    int         fill;
    logic [9:0] sym;
    logic [9:0] nxt;
    int         inc;
    bit         vld;
    bit         add;
    bit         del;
    bit         unf;
    bit         ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic void row(bit en, int fill, logic [9:0] s, logic [9:0] nx,
                              int inc, bit vld, bit add, bit del, bit unf, bit ovf);
    vec_t v;
    v = '{en, fill, s, nx, inc, vld, add, del, unf, ovf};
    vecs.push_back(v);
  endfunction

  function automatic int pick_fill();
    int vals[8];
    vals = '{3, 4, 5, 8, 11, 12, 16, 7};
    if ($urandom_range(0, 49) == 0) return 0;
    return vals[$urandom_range(0, 7)];
  endfunction

  function automatic logic [9:0] pick_sym();
    int r;
    r = $urandom_range(0, 9);
    if (r < 2) return COM;
    if (r < 6) return SKP;
    return 10'($urandom_range(0, 255));
  endfunction

  initial begin
    int n;
    bus.enable = 1'b0; bus.fill_level = '0; bus.rd_sym = DAT; bus.rd_sym_nxt = DAT;

    // Priming: 9 FILL cycles, then delivery.
    for (int i = 0; i < 9; i++) row(1, 8, DAT, DAT, 0, 0, 0, 0, 0, 0);
    row(1, 8, DAT, DAT, 1, 1, 0, 0, 0, 0);
    // Insert once per set at low fill.
    row(1, 4, COM, SKP, 1, 1, 0, 0, 0, 0);
    row(1, 4, SKP, SKP, 0, 1, 1, 0, 0, 0);
    row(1, 4, SKP, SKP, 1, 1, 0, 0, 0, 0);
    row(1, 4, SKP, DAT, 1, 1, 0, 0, 0, 0);
    row(1, 4, DAT, DAT, 1, 1, 0, 0, 0, 0);
    // Delete at high fill; a lone SKP is never deleted.
    row(1, 12, COM, SKP, 1, 1, 0, 0, 0, 0);
    row(1, 12, SKP, SKP, 2, 1, 0, 1, 0, 0);
    row(1, 12, DAT, DAT, 1, 1, 0, 0, 0, 0);
    row(1, 12, COM, SKP, 1, 1, 0, 0, 0, 0);
    row(1, 12, SKP, DAT, 1, 1, 0, 0, 0, 0);
    row(1, 12, DAT, DAT, 1, 1, 0, 0, 0, 0);
    // Low fill without ordered sets: no adjustment.
    for (int i = 0; i < 4; i++) row(1, 3, DAT, DAT, 1, 1, 0, 0, 0, 0);
    // Overflow is a flag only; deletion still proceeds.
    row(1, 16, DAT, DAT, 1, 1, 0, 0, 0, 1);
    row(1, 16, COM, SKP, 1, 1, 0, 0, 0, 1);
    row(1, 16, SKP, SKP, 2, 1, 0, 1, 0, 1);
    row(1, 16, DAT, DAT, 1, 1, 0, 0, 0, 1);
    // Threshold boundaries are exclusive.
    row(1, 5, COM, SKP, 1, 1, 0, 0, 0, 0);
    row(1, 5, SKP, SKP, 1, 1, 0, 0, 0, 0);
    row(1, 11, SKP, SKP, 1, 1, 0, 0, 0, 0);
    row(1, 11, DAT, DAT, 1, 1, 0, 0, 0, 0);
    // Underflow, then disable.
    row(1, 0, DAT, DAT, 0, 0, 0, 0, 1, 0);
    row(0, 8, DAT, DAT, 0, 0, 0, 0, 0, 0);

    do_reset();
    chk("reset add_cnt", int'(bus.add_cnt), 0);
    chk("reset del_cnt", int'(bus.del_cnt), 0);

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].fill, vecs[i].sym, vecs[i].nxt);
      chk($sformatf("vec%0d rd_inc", i), int'(bus.rd_inc), vecs[i].inc);
      chk($sformatf("vec%0d out_vld", i), int'(bus.out_vld), int'(vecs[i].vld));
      chk($sformatf("vec%0d skp_added", i), int'(bus.skp_added), int'(vecs[i].add));
      chk($sformatf("vec%0d skp_deleted", i), int'(bus.skp_deleted), int'(vecs[i].del));
      chk($sformatf("vec%0d underflow", i), int'(bus.underflow), int'(vecs[i].unf));
      chk($sformatf("vec%0d overflow", i), int'(bus.overflow), int'(vecs[i].ovf));
      tick();
    end
    chk("table add_cnt", int'(bus.add_cnt), 1);
    chk("table del_cnt", int'(bus.del_cnt), 2);

    // Low fill keeps priming past the minimum; reaching half-full then releases at once.
    for (int i = 0; i < 12; i++) begin
      drive(1, 3, DAT, DAT);
      chk("prime low out_vld", int'(bus.out_vld), 0);
      tick();
    end
    drive(1, 8, DAT, DAT);
    chk("prime release hold", int'(bus.out_vld), 0);
    tick();
    drive(1, 8, DAT, DAT);
    chk("prime release vld", int'(bus.out_vld), 1);
    tick();

    // Underflow re-primes for exactly 9 cycles.
    drive(1, 0, DAT, DAT);
    chk("unf pulse", int'(bus.underflow), 1);
    chk("unf rd_inc", int'(bus.rd_inc), 0);
    chk("unf out_vld", int'(bus.out_vld), 0);
    tick();
    n = 0;
    while (n < 30) begin
      drive(1, 8, DAT, DAT);
      if (bus.out_vld) break;
      n++;
      tick();
    end
    chk("reprime cycles", n, 9);
    tick();

    // Saturation of the add counter.
    for (int i = 0; i < 300; i++) begin
      drive(1, 4, COM, SKP); chk_model("sat com"); tick();
      drive(1, 4, SKP, DAT); chk_model("sat skp"); tick();
      drive(1, 4, SKP, DAT); tick();
      drive(1, 4, DAT, DAT); tick();
    end
    chk("add_cnt saturated", int'(bus.add_cnt), 255);

    // Asynchronous reset in the middle of an ordered set.
    drive(1, 4, COM, SKP); tick();
    drive(1, 4, SKP, SKP);
    chk("pre-reset add", int'(bus.skp_added), 1);
    rst_n = 1'b0;
    #1;
    chk("async rst rd_inc", int'(bus.rd_inc), 0);
    chk("async rst out_vld", int'(bus.out_vld), 0);
    chk("async rst skp_added", int'(bus.skp_added), 0);
    chk("async rst add_cnt", int'(bus.add_cnt), 0);
    chk("async rst del_cnt", int'(bus.del_cnt), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) != 0), pick_fill(), pick_sym(), pick_sym());
      chk_model($sformatf("rnd%0d", i));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
